saber_sequencer: RTL

Ignition/retraction controller for the lightsaber. It sits between the user controls and the on/off, length, blade-config and power blocks. It drives the blade-enable that gates the downstream setting registers, ramps the blade length up and down over a fixed number of cycles, and applies blade configuration only at ignition. It forces a retract and lockout when the power block raises its warning.

---
 rtl/saber_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/saber_sequencer.sv
// Lightsaber ignition/retraction sequencer: gates the blade setting registers,
// ramps blade length up/down, latches blade config at ignition, locks out on low power.
module saber_sequencer #(
    parameter int STEP_IGN   = 10,
    parameter int STEP_RET   = 20,
    parameter int MIN_IGNITE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on_req,
    input  logic [1:0] len_in_i,
    input  logic [5:0] len_dec_i,
    input  logic [1:0] cfg_i,
    input  logic [1:0] pwr_use_i,
    input  logic [7:0] pwr_level,
    input  logic       pwr_warn,
    output logic       blade_en,
    output logic [8:0] cur_len,
    output logic [1:0] cfg_o,
    output logic [1:0] pwr_use_o,
    output logic [2:0] state_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_IGNITE  = 3'd1,
        ST_ON      = 3'd2,
        ST_RETRACT = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [8:0] STEP_IGN_9 = 9'(STEP_IGN);
    localparam logic [8:0] STEP_RET_9 = 9'(STEP_RET);
    localparam logic [7:0] MIN_LVL    = 8'(MIN_IGNITE);

    state_t     state, state_n;
    logic [8:0] len_n;
    logic [1:0] cfg_n;
    logic [1:0] pwr_use_n;
    logic       lock, lock_n;

    logic [6:0] dec_ext;
    logic [6:0] dec_clamp;
    logic [8:0] tgt;
    logic [9:0] grow;
    logic [8:0] drop;
    logic [8:0] diff_up;
    logic [8:0] diff_dn;
    logic       level_ok;
    logic       ignite_ok;

    // Target length in hundredths, fraction saturated at 99.
    always_comb begin
        dec_ext   = {1'b0, len_dec_i};
        dec_clamp = (dec_ext > 7'd99) ? 7'd99 : dec_ext;
        tgt       = 9'(len_in_i) * 9'd100 + 9'(dec_clamp);
    end

    always_comb begin
        grow      = {1'b0, cur_len} + {1'b0, STEP_IGN_9};
        drop      = cur_len - STEP_RET_9;
        diff_up   = tgt - cur_len;
        diff_dn   = cur_len - tgt;
        level_ok  = (pwr_level >= MIN_LVL);
        ignite_ok = on_req && !pwr_warn && level_ok && (tgt != 9'd0);
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        len_n   = cur_len;
        cfg_n   = cfg_o;
        lock_n  = lock;
        case (state)
            ST_OFF: begin
                len_n = 9'd0;
                if (ignite_ok) begin
                    state_n = ST_IGNITE;
                    cfg_n   = cfg_i;
                    lock_n  = 1'b0;
                end
            end
            ST_IGNITE: begin
                if (pwr_warn) begin
                    state_n = ST_RETRACT;
                    lock_n  = 1'b1;
                end else if (!on_req) begin
                    state_n = ST_RETRACT;
                end else if (grow >= {1'b0, tgt}) begin
                    len_n   = tgt;
                    state_n = ST_ON;
                end else begin
                    len_n = grow[8:0];
                end
            end
            ST_ON: begin
                if (pwr_warn) begin
                    state_n = ST_RETRACT;
                    lock_n  = 1'b1;
                end else if (!on_req) begin
                    state_n = ST_RETRACT;
                end else if (tgt > cur_len) begin
                    len_n = (diff_up <= STEP_IGN_9) ? tgt : grow[8:0];
                end else if (tgt < cur_len) begin
                    len_n = (diff_dn <= STEP_RET_9) ? tgt : drop;
                end
            end
            ST_RETRACT: begin
                // Retraction always runs to zero; a warning seen on the way still locks out.
                if (pwr_warn) lock_n = 1'b1;
                if (cur_len <= STEP_RET_9) begin
                    len_n   = 9'd0;
                    state_n = (lock || pwr_warn) ? ST_LOCKOUT : ST_OFF;
                end else begin
                    len_n = drop;
                end
            end
            ST_LOCKOUT: begin
                len_n = 9'd0;
                if (!pwr_warn && level_ok && !on_req) state_n = ST_OFF;
            end
            default: begin
                state_n = ST_OFF;
                len_n   = 9'd0;
            end
        endcase
    end

    // Power-use mode is registered from the next state so it never follows inputs directly.
    always_comb begin
        pwr_use_n = 2'd0;
        case (state_n)
            ST_IGNITE:  pwr_use_n = 2'd3;
            ST_ON:      pwr_use_n = pwr_use_i;
            ST_RETRACT: pwr_use_n = 2'd1;
            default:    pwr_use_n = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_OFF;
            cur_len   <= 9'd0;
            cfg_o     <= 2'd0;
            pwr_use_o <= 2'd0;
            lock      <= 1'b0;
        end else begin
            state     <= state_n;
            cur_len   <= len_n;
            cfg_o     <= cfg_n;
            pwr_use_o <= pwr_use_n;
            lock      <= lock_n;
        end
    end

    always_comb begin
        state_o  = state;
        blade_en = (state == ST_IGNITE) || (state == ST_ON) || (state == ST_RETRACT);
        busy     = (state == ST_IGNITE) || (state == ST_RETRACT);
    end

endmodule
